// File: rtl/dice_pkg.sv
// Shared types and constants for the dice core's I2C register front end.
package dice_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ACK_ADDR = 4'd2,
        SUB      = 4'd3,
        ACK_SUB  = 4'd4,
        WDATA    = 4'd5,
        ACK_WR   = 4'd6,
        RDATA    = 4'd7,
        MACK     = 4'd8,
        IGNORE   = 4'd9
    } i2c_state_t;

    localparam logic [6:0] I2C_DEV_ADDR_DEFAULT = 7'h70;

endpackage

// File: rtl/i2c_line_cond.sv
// Synchroniser plus glitch filter for one I2C line; emits filtered level and
// registered single-cycle rise/fall pulses.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   level_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Idle bus is high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            cnt     <= '0;
            level   <= 1'b1;
            level_q <= 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            level_q <= level;
            rise    <= level & ~level_q;
            fall    <= ~level & level_q;
            if (sync_out == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                level <= sync_out;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target bridging the SCL/SDA pads to the dice control/status registers:
// write strobes with auto-incrementing sub-address, reads from a combinational port.
module i2c_reg_slave
    import dice_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = I2C_DEV_ADDR_DEFAULT,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] wr_data,
    output logic       wr_stb,
    input  logic [7:0] rd_data,
    output logic       rd_stb,
    output logic       busy
);

    logic       scl_lvl, scl_rise, scl_fall;
    logic       sda_lvl, sda_rise, sda_fall;
    logic       start_det, stop_det;
    logic [7:0] shift;
    logic [7:0] rx_byte;
    logic [3:0] bit_cnt;
    logic       rw;
    logic       load_pend;
    i2c_state_t state;

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (scl_in),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sda_in),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign rx_byte   = {shift[6:0], sda_lvl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            wr_data   <= '0;
            wr_stb    <= 1'b0;
            rd_stb    <= 1'b0;
            busy      <= 1'b0;
            shift     <= '0;
            bit_cnt   <= '0;
            rw        <= 1'b0;
            load_pend <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            rd_stb <= 1'b0;
            if (!ena) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                bit_cnt   <= '0;
                load_pend <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                load_pend <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                bit_cnt   <= '0;
                load_pend <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: if (scl_rise) begin
                        shift <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            rw      <= sda_lvl;
                            if (shift[6:0] == DEV_ADDR) begin
                                busy  <= 1'b1;
                                state <= ACK_ADDR;
                            end else begin
                                state <= IGNORE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    // ACK states: first SCL fall pulls SDA low, the next one ends the ACK.
                    ACK_ADDR: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (!rw) begin
                            sda_oe <= 1'b0;
                            state  <= SUB;
                        end else begin
                            shift   <= {rd_data[6:0], 1'b0};
                            sda_oe  <= ~rd_data[7];
                            rd_stb  <= 1'b1;
                            bit_cnt <= 4'd1;
                            state   <= RDATA;
                        end
                    end
                    SUB: if (scl_rise) begin
                        shift <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt  <= '0;
                            reg_addr <= rx_byte;
                            state    <= ACK_SUB;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ACK_SUB: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= WDATA;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shift <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            wr_data <= rx_byte;
                            wr_stb  <= 1'b1;
                            state   <= ACK_WR;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ACK_WR: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe   <= 1'b0;
                            reg_addr <= reg_addr + 8'd1;
                            state    <= WDATA;
                        end
                    end
                    RDATA: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= MACK;
                        end else begin
                            sda_oe  <= ~shift[7];
                            shift   <= {shift[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    // rd_data follows reg_addr combinationally, so the reload waits one cycle
                    // after the increment to pick up the next register.
                    MACK: begin
                        if (load_pend) begin
                            load_pend <= 1'b0;
                            shift     <= rd_data;
                            rd_stb    <= 1'b1;
                            bit_cnt   <= '0;
                            state     <= RDATA;
                        end else if (scl_rise) begin
                            if (!sda_lvl) begin
                                reg_addr  <= reg_addr + 8'd1;
                                load_pend <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    IGNORE: sda_oe <= 1'b0;
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
